lif_scheduler: RTL and testbench



---
 rtl/lif_pkg.sv | 28 ++
 rtl/lif_scheduler_if.sv | 29 ++
 rtl/lif_spike_fifo.sv | 63 ++++++
 rtl/lif_scheduler.sv | 138 +++++++++++++
 tb/tb_lif_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron scheduler: FSM states,
// index-width sizing and the saturating adder used by the update datapath.
package lif_pkg;

  localparam int STATE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } lif_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Adds in width+1 bits and clamps to 2^width-1; width may be 1..16.
  function automatic logic [15:0] sat_add(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input int unsigned width);
    logic [16:0] s;
    logic [16:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (17'd1 << width) - 17'd1;
    return (s > lim) ? lim[15:0] : s[15:0];
  endfunction

endpackage

// File: rtl/lif_scheduler_if.sv
// Control, current-write, monitor and spike-stream signals of lif_scheduler.
// master = the chip top-level / driver side, slave = the scheduler.
interface lif_scheduler_if #(
  parameter int IDX_W   = 2,
  parameter int STATE_W = 8
);
  logic               tick;
  logic               cur_wr;
  logic [IDX_W-1:0]   cur_addr;
  logic [STATE_W-1:0] cur_data;
  logic [IDX_W-1:0]   mon_sel;
  logic [STATE_W-1:0] mon_state;
  logic               busy;
  logic               tick_done;
  logic               spike_valid;
  logic [IDX_W-1:0]   spike_id;
  logic               spike_ready;
  logic               overflow;

  modport master (
    output tick, cur_wr, cur_addr, cur_data, mon_sel, spike_ready,
    input  mon_state, busy, tick_done, spike_valid, spike_id, overflow
  );

  modport slave (
    input  tick, cur_wr, cur_addr, cur_data, mon_sel, spike_ready,
    output mon_state, busy, tick_done, spike_valid, spike_id, overflow
  );
endinterface

// File: rtl/lif_spike_fifo.sv
// Spike-ID queue. A push into a full queue is kept only when a pop happens
// in the same cycle; otherwise it is dropped and the sticky overflow flag set.
module lif_spike_fifo
  import lif_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overflow
);
  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             accept;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop    = pop_req && !empty;
  // Slot under rd_ptr is read out this cycle, so a full queue may overwrite it.
  assign accept = push && (!full || pop);

  assign head  = mem[rd_ptr];
  assign valid = !empty;

  // NOTE: the storage is reset so spike_id reads 0 out of reset; without that
  // requirement it could be left unreset and mapped to plain RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update per
// neuron per tick, spikes queued as neuron IDs. LIF_REFRACTORY_EN adds a
// 3-sweep refractory period after each spike.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int STATE_W    = STATE_W_DEF,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  lif_scheduler_if.slave bus
);
  localparam int IDX_W = idx_width(N_NEURONS);
  localparam logic [STATE_W:0]   THR  = (STATE_W+1)'(THRESHOLD);
  localparam logic [IDX_W-1:0]   LAST = IDX_W'(N_NEURONS - 1);

  lif_state_e         state;
  logic [IDX_W-1:0]   idx;
  logic               busy_q;
  logic               tick_done_q;
  logic [STATE_W-1:0] mon_q;

  logic [STATE_W-1:0] membrane [N_NEURONS];
  logic [STATE_W-1:0] current  [N_NEURONS];

  logic [STATE_W-1:0] m_cur;
  logic [STATE_W-1:0] leaked;
  logic [STATE_W-1:0] sum;
  logic               fire;

`ifdef LIF_REFRACTORY_EN
  logic [1:0] refr [N_NEURONS];
  logic       refr_active;
  assign refr_active = (refr[idx] != 2'd0);
`endif

  // NOTE: every output of this block gets a value before any condition, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    m_cur  = membrane[idx];
    leaked = m_cur - (m_cur >> LEAK_SHIFT);
    sum    = STATE_W'(sat_add(16'(leaked), 16'(current[idx]), STATE_W));
    fire   = (state == SCAN) && ({1'b0, sum} >= THR);
`ifdef LIF_REFRACTORY_EN
    if (refr_active) fire = 1'b0;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // the block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      busy_q      <= 1'b0;
      tick_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tick_done_q <= 1'b0;
          if (bus.tick) begin
            state  <= SCAN;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        SCAN: begin
          if (idx == LAST) begin
            state       <= DONE;
            tick_done_q <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          tick_done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Membranes and currents are architectural state cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        membrane[i] <= '0;
        current[i]  <= '0;
`ifdef LIF_REFRACTORY_EN
        refr[i]     <= 2'd0;
`endif
      end
      mon_q <= '0;
    end else begin
      // The update above already read the old current for this neuron.
      if (bus.cur_wr) current[bus.cur_addr] <= bus.cur_data;
      if (state == SCAN) begin
`ifdef LIF_REFRACTORY_EN
        if (refr_active) begin
          membrane[idx] <= '0;
          refr[idx]     <= refr[idx] - 2'd1;
        end else begin
          membrane[idx] <= fire ? '0 : sum;
          if (fire) refr[idx] <= 2'd3;
        end
`else
        membrane[idx] <= fire ? '0 : sum;
`endif
      end
      mon_q <= membrane[bus.mon_sel];
    end
  end

  lif_spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data (idx),
    .pop_req   (bus.spike_ready),
    .head      (bus.spike_id),
    .valid     (bus.spike_valid),
    .overflow  (bus.overflow)
  );

  assign bus.busy      = busy_q;
  assign bus.tick_done = tick_done_q;
  assign bus.mon_state = mon_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: table-driven sweeps, directed corner
// sequences and a randomized run against a sweep-level reference model.
module tb_lif_scheduler;
  import lif_pkg::*;

  localparam int N     = 4;
  localparam int SW    = 8;
  localparam int IW    = 2;
  localparam int THR   = 200;
  localparam int LS    = 2;
  localparam int DEPTH = 4;
  localparam int MAXV  = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lif_scheduler_if #(.IDX_W(IW), .STATE_W(SW)) bus ();
  lif_scheduler_if #(.IDX_W(IW), .STATE_W(SW)) bus2 ();

  lif_scheduler #(.N_NEURONS(N), .STATE_W(SW), .THRESHOLD(THR),
                  .LEAK_SHIFT(LS), .FIFO_DEPTH(DEPTH))
    dut (.clk(clk), .rst(rst), .bus(bus));

  lif_scheduler #(.N_NEURONS(N), .STATE_W(SW), .THRESHOLD(255),
                  .LEAK_SHIFT(LS), .FIFO_DEPTH(DEPTH))
    dut_sat (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  // Reference model: membranes, currents, spike queue, sweep position
  // (-1 idle, 0..N-1 neuron updated at the coming edge, N = done cycle).
  int mm [N];
  int mc [N];
  int mr [N];
  int mq [$];
  bit movf;
  int pos;
  int exp_mon;

  typedef struct {
    int cur0;
    int exp_m0;
    int exp_spike;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mm[i] = 0; mc[i] = 0; mr[i] = 0;
    end
    mq.delete();
    movf    = 0;
    pos     = -1;
    exp_mon = 0;
  endtask

  task automatic model_edge(input int t, input int wr, input int addr,
                            input int data, input int rdy, input int sel);
    int  nq;
    bit  pop;
    bit  spike;
    int  k;
    int  total;
    nq      = mq.size();
    pop     = (nq > 0) && (rdy != 0);
    spike   = 0;
    k       = 0;
    exp_mon = mm[sel];
    if (pos >= 0 && pos < N) begin
      k = pos;
`ifdef LIF_REFRACTORY_EN
      if (mr[k] > 0) begin
        mm[k] = 0;
        mr[k] = mr[k] - 1;
      end else begin
`endif
        total = mm[k] - mm[k] / (1 << LS) + mc[k];
        if (total > MAXV) total = MAXV;
        spike = (total >= THR);
        mm[k] = spike ? 0 : total;
`ifdef LIF_REFRACTORY_EN
        if (spike) mr[k] = 3;
      end
`endif
    end
    if (pop) void'(mq.pop_front());
    if (spike) begin
      if (nq < DEPTH || pop) mq.push_back(k);
      else movf = 1;
    end
    if (wr != 0) mc[addr] = data;
    if (pos == -1) pos = (t != 0) ? 0 : -1;
    else if (pos < N) pos = pos + 1;
    else pos = -1;
  endtask

  task automatic compare_all();
    check("busy", bus.busy, 32'(pos != -1));
    check("tick_done", bus.tick_done, 32'(pos == N));
    check("spike_valid", bus.spike_valid, 32'(mq.size() > 0));
    if (mq.size() > 0) check("spike_id", bus.spike_id, mq[0]);
    check("overflow", bus.overflow, 32'(movf));
    check("mon_state", bus.mon_state, exp_mon);
  endtask

  // One clock cycle: drive at negedge, advance the model, compare at next negedge.
  task automatic step(input int t, input int wr, input int addr, input int data,
                      input int rdy, input int sel);
    bus.tick        = t[0];
    bus.cur_wr      = wr[0];
    bus.cur_addr    = IW'(addr);
    bus.cur_data    = SW'(data);
    bus.spike_ready = rdy[0];
    bus.mon_sel     = IW'(sel);
    model_edge(t, wr, addr, data, rdy, sel);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic sweep(input int sel);
    step(1, 0, 0, 0, 0, sel);
    repeat (N + 1) step(0, 0, 0, 0, 0, sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.tick = 1'b0; bus.cur_wr = 1'b0; bus.spike_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step2(input int t, input int wr, input int addr, input int data,
                       input int rdy, input int sel);
    bus2.tick        = t[0];
    bus2.cur_wr      = wr[0];
    bus2.cur_addr    = IW'(addr);
    bus2.cur_data    = SW'(data);
    bus2.spike_ready = rdy[0];
    bus2.mon_sel     = IW'(sel);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int pulses;
    bit seen;

    rst = 1'b1;
    bus.tick = 1'b0; bus.cur_wr = 1'b0; bus.cur_addr = '0; bus.cur_data = '0;
    bus.mon_sel = '0; bus.spike_ready = 1'b0;
    bus2.tick = 1'b0; bus2.cur_wr = 1'b0; bus2.cur_addr = '0; bus2.cur_data = '0;
    bus2.mon_sel = '0; bus2.spike_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle behaviour.
    check("rst_busy", bus.busy, 0);
    check("rst_tick_done", bus.tick_done, 0);
    check("rst_spike_valid", bus.spike_valid, 0);
    check("rst_spike_id", bus.spike_id, 0);
    check("rst_overflow", bus.overflow, 0);
    for (int s = 0; s < N; s++) begin
      step(0, 0, 0, 0, 0, s);
      step(0, 0, 0, 0, 0, s);
      check("idle_mon", bus.mon_state, 0);
    end

    // tick_done latency: N+1 edges after tick is raised.
    step(1, 0, 0, 0, 0, 0);
    cnt  = 1;
    seen = 0;
    while (!seen && cnt < 20) begin
      step(0, 0, 0, 0, 0, 0);
      cnt++;
      seen = bus.tick_done;
    end
    check("tick_done_latency", cnt, N + 1);
    step(0, 0, 0, 0, 0, 0);

    // Table-driven single-neuron integration/leak/threshold sequence.
    tbl[0] = '{100, 100, 0};
    tbl[1] = '{100, 175, 0};
    tbl[2] = '{100,   0, 1};
    tbl[3] = '{ 50,  50, 0};
    tbl[4] = '{  0,  38, 0};
    tbl[5] = '{170, 199, 0};
    tbl[6] = '{  1, 151, 0};
    tbl[7] = '{ 86,   0, 1};
    do_reset();
    for (int v = 0; v < 8; v++) begin
      step(0, 1, 0, tbl[v].cur0, 0, 0);
      sweep(0);
      check($sformatf("tbl%0d_m0", v), bus.mon_state, tbl[v].exp_m0);
      check($sformatf("tbl%0d_spike", v), bus.spike_valid, tbl[v].exp_spike);
      if (tbl[v].exp_spike != 0) begin
        check($sformatf("tbl%0d_id", v), bus.spike_id, 0);
        step(0, 0, 0, 0, 1, 0);
      end
    end

    // All neurons saturate: four ordered spikes, then four drops -> overflow.
    do_reset();
    for (int a = 0; a < N; a++) step(0, 1, a, 255, 0, 0);
    sweep(0);
    check("full_valid", bus.spike_valid, 1);
    check("full_no_ovf", bus.overflow, 0);
    sweep(0);
    check("drop_ovf", bus.overflow, 1);
    for (int i = 0; i < N; i++) begin
      check("order_id", bus.spike_id, i);
      step(0, 0, 0, 0, 1, 0);
    end
    check("drained", bus.spike_valid, 0);
    check("ovf_sticky", bus.overflow, 1);

    // Tick while busy ignored; current write to the active neuron lands next sweep.
    do_reset();
    step(0, 1, 2, 10, 0, 2);
    step(1, 0, 0, 0, 0, 2);
    pulses = 0;
    for (int j = 0; j < N + 4; j++) begin
      step((j == 2 || j == N) ? 1 : 0, (j == 2) ? 1 : 0, 2, 150, 0, 2);
      if (bus.tick_done) pulses++;
    end
    check("busy_tick_pulses", pulses, 1);
    check("old_cur_used", bus.mon_state, 10);
    sweep(2);
    check("new_cur_next", bus.mon_state, 158);

    // Asynchronous reset in the middle of a sweep.
    do_reset();
    step(0, 1, 0, 255, 0, 0);
    sweep(0);
    check("pre_rst_valid", bus.spike_valid, 1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_tick_done", bus.tick_done, 0);
    check("mid_rst_valid", bus.spike_valid, 0);
    check("mid_rst_id", bus.spike_id, 0);
    check("mid_rst_ovf", bus.overflow, 0);
    check("mid_rst_mon", bus.mon_state, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 40, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    cnt  = 1;
    seen = 0;
    while (!seen && cnt < 20) begin
      step(0, 0, 0, 0, 0, 0);
      cnt++;
      seen = bus.tick_done;
    end
    check("post_rst_latency", cnt, N + 1);
    step(0, 0, 0, 0, 0, 0);
    check("post_rst_m0", bus.mon_state, 40);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 3) == 0) ? 1 : 0,
           ($urandom_range(0, 2) == 0) ? 1 : 0,
           int'($urandom_range(0, N - 1)),
           int'($urandom_range(0, 120)),
           ($urandom_range(0, 2) == 0) ? 1 : 0,
           int'($urandom_range(0, N - 1)));
    end

    // Saturation on the THRESHOLD=255 instance: 75+255 clamps to 255 and fires.
    step2(0, 1, 0, 100, 0, 0);
    step2(0, 1, 1, 254, 0, 0);
    step2(1, 0, 0, 0, 0, 0);
    repeat (N + 1) step2(0, 0, 0, 0, 0, 0);
    check("sat_no_spike", bus2.spike_valid, 0);
    step2(0, 1, 0, 255, 0, 1);
    check("sat_m1_254", bus2.mon_state, 254);
    step2(0, 1, 1, 0, 0, 0);
    step2(1, 0, 0, 0, 0, 0);
    repeat (N + 1) step2(0, 0, 0, 0, 0, 0);
    check("sat_busy", bus2.busy, 0);
    check("sat_spike", bus2.spike_valid, 1);
    check("sat_id", bus2.spike_id, 0);
    step2(0, 0, 0, 0, 0, 0);
    check("sat_m0", bus2.mon_state, 0);
    step2(0, 0, 0, 0, 1, 1);
    check("sat_m1", bus2.mon_state, 191);
    check("sat_single", bus2.spike_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
